// File: rtl/spi_frame_deframer.sv
// SPI frame deframer: synchronises an asynchronous SPI clock/data pair, hunts for a
// header, reads a channel ID and steers fixed-length payload words to per-channel strobes.
module spi_frame_deframer #(
   parameter int               SYNC_STAGES   = 2,
   parameter int               HDR_W         = 8,
   parameter logic [HDR_W-1:0] HDR_PATTERN   = 8'hFF,
   parameter int               NUM_CH        = 2,
   parameter int               CH_ID_W       = 1,
   parameter int               WORD_W        = 8,
   parameter int               PAYLOAD_WORDS = 2048,
   parameter int               TIMEOUT_CYC   = 4000
) (
   input  logic                CLK_40,
   input  logic                reset,
   input  logic                enable,
   input  logic                SPI_clk_CDC,
   input  logic                MISO_CDC,
   output logic [WORD_W-1:0]   word_data,
   output logic                word_valid,
   output logic [CH_ID_W-1:0]  word_ch,
   output logic [NUM_CH-1:0]   ch_write,
   output logic                frame_start,
   output logic                frame_done,
   output logic                frame_err,
   output logic                sync_lost,
   output logic                busy
);

   localparam int CNT_W    = $clog2(PAYLOAD_WORDS + 1);
   localparam int TO_W     = $clog2(TIMEOUT_CYC + 1);
   localparam int BITS_MAX = (WORD_W > CH_ID_W) ? WORD_W : CH_ID_W;
   localparam int BIT_W    = (BITS_MAX > 1) ? $clog2(BITS_MAX) : 1;

   localparam logic [CNT_W-1:0]   LAST_WORD     = CNT_W'(PAYLOAD_WORDS - 1);
   localparam logic [TO_W-1:0]    TO_LIMIT      = TO_W'(TIMEOUT_CYC);
   localparam logic [BIT_W-1:0]   WORD_LAST_BIT = BIT_W'(WORD_W - 1);
   localparam logic [BIT_W-1:0]   ID_LAST_BIT   = BIT_W'(CH_ID_W - 1);
   localparam logic [CH_ID_W:0]   NUM_CH_ID     = (CH_ID_W + 1)'(NUM_CH);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] HUNT    = 2'd1;
   localparam logic [1:0] CHID    = 2'd2;
   localparam logic [1:0] PAYLOAD = 2'd3;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] miso_sync;
   logic                   clk_prev;
   logic                   spi_rise;
   logic                   spi_bit;
   logic                   to_hit;
   logic [1:0]             state;
   logic [HDR_W-1:0]       hunt_sr;
   logic [HDR_W-1:0]       hunt_next;
   logic [CH_ID_W-1:0]     id_sr;
   logic [CH_ID_W-1:0]     id_next;
   logic [WORD_W-1:0]      word_sr;
   logic [WORD_W-1:0]      word_next;
   logic [BIT_W-1:0]       bit_cnt;
   logic [CNT_W-1:0]       word_cnt;
   logic [TO_W-1:0]        to_cnt;

   // Both inputs go through identical synchroniser depth so data stays aligned to the clock.
   assign spi_rise  = clk_sync[SYNC_STAGES-1] & ~clk_prev;
   assign spi_bit   = miso_sync[SYNC_STAGES-1];
   assign to_hit    = (to_cnt == TO_LIMIT) & ~spi_rise;
   assign hunt_next = HDR_W'({hunt_sr, spi_bit});
   assign id_next   = CH_ID_W'({id_sr, spi_bit});
   assign word_next = WORD_W'({word_sr, spi_bit});
   assign busy      = (state == CHID) || (state == PAYLOAD);

   // NOTE: every register here, synchroniser flops included, uses <= so all of them
   // update from the same pre-edge values regardless of statement order.
   always_ff @(posedge CLK_40) begin
      if (reset) begin
         clk_sync    <= '0;
         miso_sync   <= '0;
         clk_prev    <= 1'b0;
         state       <= IDLE;
         hunt_sr     <= '0;
         id_sr       <= '0;
         word_sr     <= '0;
         bit_cnt     <= '0;
         word_cnt    <= '0;
         to_cnt      <= '0;
         word_data   <= '0;
         word_valid  <= 1'b0;
         word_ch     <= '0;
         ch_write    <= '0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
         sync_lost   <= 1'b0;
      end else begin
         clk_sync  <= SYNC_STAGES'({clk_sync, SPI_clk_CDC});
         miso_sync <= SYNC_STAGES'({miso_sync, MISO_CDC});
         clk_prev  <= clk_sync[SYNC_STAGES-1];

         // Strobes default low so each fires for exactly one cycle.
         word_valid  <= 1'b0;
         ch_write    <= '0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
         sync_lost   <= 1'b0;

         if (spi_rise) begin
            to_cnt <= '0;
         end else if (to_cnt != TO_LIMIT) begin
            to_cnt <= to_cnt + 1'b1;
         end

         if (!enable) begin
            state   <= IDLE;
            bit_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state   <= HUNT;
                  hunt_sr <= '0;
               end
               HUNT: begin
                  if (spi_rise) begin
                     hunt_sr <= hunt_next;
                     if (hunt_next == HDR_PATTERN) begin
                        state   <= CHID;
                        bit_cnt <= '0;
                        id_sr   <= '0;
                     end
                  end
               end
               CHID: begin
                  if (spi_rise) begin
                     id_sr   <= id_next;
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == ID_LAST_BIT) begin
                        bit_cnt <= '0;
                        if ({1'b0, id_next} < NUM_CH_ID) begin
                           state       <= PAYLOAD;
                           word_ch     <= id_next;
                           frame_start <= 1'b1;
                           word_cnt    <= '0;
                        end else begin
                           state     <= HUNT;
                           hunt_sr   <= '0;
                           frame_err <= 1'b1;
                        end
                     end
                  end else if (to_hit) begin
                     state     <= HUNT;
                     hunt_sr   <= '0;
                     bit_cnt   <= '0;
                     sync_lost <= 1'b1;
                  end
               end
               PAYLOAD: begin
                  if (spi_rise) begin
                     word_sr <= word_next;
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == WORD_LAST_BIT) begin
                        bit_cnt    <= '0;
                        word_data  <= word_next;
                        word_valid <= 1'b1;
                        ch_write   <= NUM_CH'(1) << word_ch;
                        word_cnt   <= word_cnt + 1'b1;
                        if (word_cnt == LAST_WORD) begin
                           frame_done <= 1'b1;
                           word_cnt   <= '0;
                           state      <= HUNT;
                           hunt_sr    <= '0;
                        end
                     end
                  end else if (to_hit) begin
                     state     <= HUNT;
                     hunt_sr   <= '0;
                     bit_cnt   <= '0;
                     sync_lost <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_frame_deframer.sv
// Directed bench for spi_frame_deframer: frame table, timeout/abort sequences and a
// jittered 1 MHz random stream checked against a log of the words sent.
`timescale 1ns/100ps
module tb_spi_frame_deframer;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       spi_clk;
   logic       miso;
   logic [7:0] word_data;
   logic       word_valid;
   logic [1:0] word_ch;
   logic [2:0] ch_write;
   logic       frame_start;
   logic       frame_done;
   logic       frame_err;
   logic       sync_lost;
   logic       busy;

   always #12.5 clk = ~clk;

   spi_frame_deframer #(
      .SYNC_STAGES(2), .HDR_W(8), .HDR_PATTERN(8'hFF), .NUM_CH(3), .CH_ID_W(2),
      .WORD_W(8), .PAYLOAD_WORDS(4), .TIMEOUT_CYC(4000)
   ) dut (
      .CLK_40(clk), .reset(reset), .enable(enable), .SPI_clk_CDC(spi_clk),
      .MISO_CDC(miso), .word_data(word_data), .word_valid(word_valid),
      .word_ch(word_ch), .ch_write(ch_write), .frame_start(frame_start),
      .frame_done(frame_done), .frame_err(frame_err), .sync_lost(sync_lost),
      .busy(busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Output monitor: counts pulses and logs every issued word as {ch, data}.
   int         n_start = 0, n_done = 0, n_err = 0, n_lost = 0, n_coinc = 0, n_stray = 0;
   int         n_got = 0;
   logic [9:0] got_mem [0:1023];
   logic [2:0] last_chw = '0;

   always @(negedge clk) begin
      if (!reset) begin
         if (frame_start) n_start++;
         if (frame_done) n_done++;
         if (frame_done && word_valid) n_coinc++;
         if (frame_err) n_err++;
         if (sync_lost) n_lost++;
         if (!word_valid && ch_write != 3'b000) n_stray++;
         if (word_valid) begin
            got_mem[n_got] = {word_ch, word_data};
            n_got++;
            last_chw = ch_write;
         end
      end
   end

   // Expected-word log filled by the stimulus side.
   logic [9:0] exp_mem [0:1023];
   int         n_exp = 0;
   int         rd = 0;

   int s_start, s_done, s_err, s_lost, s_coinc;
   task automatic snap();
      s_start = n_start; s_done = n_done; s_err = n_err; s_lost = n_lost; s_coinc = n_coinc;
   endtask

   int half_lo = 5, half_hi = 5;
   bit jitter = 1'b0;

   task automatic spi_bit(input logic b);
      int lo, hi;
      lo = half_lo;
      hi = half_hi;
      if (jitter) begin
         lo = lo + int'($urandom_range(10)) - 5;
         hi = hi + int'($urandom_range(10)) - 5;
      end
      miso = b;
      repeat (lo) @(negedge clk);
      spi_clk = 1'b1;
      repeat (hi) @(negedge clk);
      spi_clk = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) spi_bit(v[i]);
   endtask

   task automatic send_frame(input logic [1:0] id, input logic [31:0] words, input int n_words);
      send_bits(32'hFF, 8);
      send_bits({30'd0, id}, 2);
      for (int w = 0; w < n_words; w++) begin
         logic [7:0] b;
         b = words[31 - 8*w -: 8];
         send_bits({24'd0, b}, 8);
         if (id < 2'd3) begin
            exp_mem[n_exp] = {id, b};
            n_exp++;
         end
      end
   endtask

   task automatic compare_words(input string tag);
      check($sformatf("%s word count", tag), n_got, n_exp);
      for (int i = rd; i < n_exp && i < n_got; i++)
         check($sformatf("%s word %0d", tag, i), {22'd0, got_mem[i]}, {22'd0, exp_mem[i]});
      rd = (n_exp > n_got) ? n_exp : n_got;
      n_exp = rd;
   endtask

   typedef struct {
      logic        has_pre;
      logic [7:0]  pre;
      logic [1:0]  id;
      logic [31:0] words;
      int          exp_start;
      int          exp_err;
      int          exp_words;
      int          exp_done;
      logic [2:0]  exp_chw;
   } vec_t;

   vec_t vecs [5];

   initial begin
      vecs[0] = '{1'b0, 8'h00, 2'd1, 32'hA53C00FF, 1, 0, 4, 1, 3'b010};
      vecs[1] = '{1'b1, 8'hFE, 2'd0, 32'h11223344, 1, 0, 4, 1, 3'b001};
      vecs[2] = '{1'b0, 8'h00, 2'd3, 32'h00000000, 0, 1, 0, 0, 3'b000};
      vecs[3] = '{1'b0, 8'h00, 2'd2, 32'hFFFFFFFF, 1, 0, 4, 1, 3'b100};
      vecs[4] = '{1'b1, 8'h5A, 2'd1, 32'h0FF0817E, 1, 0, 4, 1, 3'b010};

      reset   = 1'b1;
      enable  = 1'b0;
      spi_clk = 1'b0;
      miso    = 1'b0;

      // Reset held for 4 cycles with the SPI clock toggling.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("reset outputs c%0d", i),
               {13'd0, word_data, word_valid, word_ch, ch_write, frame_start, frame_done,
                frame_err, sync_lost, busy}, 32'd0);
         spi_clk = ~spi_clk;
         miso    = ~miso;
      end
      spi_clk = 1'b0;
      miso    = 1'b0;
      reset   = 1'b0;
      repeat (6) @(negedge clk);
      check("idle after reset busy", {31'd0, busy}, 32'd0);
      check("idle after reset pulses", n_start + n_done + n_err + n_lost + n_got, 0);

      enable = 1'b1;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         int w0;
         w0 = n_got;
         snap();
         if (vecs[v].has_pre) send_bits({24'd0, vecs[v].pre}, 8);
         send_frame(vecs[v].id, vecs[v].words, 4);
         repeat (8) @(negedge clk);
         check($sformatf("v%0d frame_start", v), n_start - s_start, vecs[v].exp_start);
         check($sformatf("v%0d frame_err", v), n_err - s_err, vecs[v].exp_err);
         check($sformatf("v%0d word_valid", v), n_got - w0, vecs[v].exp_words);
         check($sformatf("v%0d frame_done", v), n_done - s_done, vecs[v].exp_done);
         check($sformatf("v%0d done with last word", v), n_coinc - s_coinc, vecs[v].exp_done);
         if (vecs[v].exp_words > 0)
            check($sformatf("v%0d ch_write", v), {29'd0, last_chw}, {29'd0, vecs[v].exp_chw});
         check($sformatf("v%0d busy after", v), {31'd0, busy}, 32'd0);
         compare_words($sformatf("v%0d", v));
      end

      // Stall after two words: sync_lost must wait for the full timeout.
      snap();
      send_frame(2'd1, 32'hC3965A00, 2);
      send_bits(32'h5, 3);
      repeat (3900) @(negedge clk);
      check("stall early sync_lost", n_lost - s_lost, 0);
      check("stall busy before timeout", {31'd0, busy}, 32'd1);
      repeat (1100) @(negedge clk);
      check("stall sync_lost", n_lost - s_lost, 1);
      check("stall frame_done", n_done - s_done, 0);
      check("stall busy after timeout", {31'd0, busy}, 32'd0);
      compare_words("stall");

      snap();
      send_frame(2'd0, 32'h01020304, 4);
      repeat (8) @(negedge clk);
      check("post-stall frame_start", n_start - s_start, 1);
      check("post-stall frame_done", n_done - s_done, 1);
      compare_words("post-stall");

      // Abort mid-word with enable low.
      send_frame(2'd2, 32'h99000000, 1);
      send_bits(32'hA, 4);
      snap();
      enable = 1'b0;
      repeat (10) @(negedge clk);
      check("abort busy", {31'd0, busy}, 32'd0);
      send_bits(32'h3FD, 10);
      repeat (8) @(negedge clk);
      check("abort pulses", (n_start - s_start) + (n_done - s_done) + (n_err - s_err)
            + (n_lost - s_lost), 0);
      compare_words("abort");
      enable = 1'b1;
      repeat (2) @(negedge clk);
      snap();
      send_frame(2'd2, 32'hDEADBEEF, 4);
      repeat (8) @(negedge clk);
      check("post-abort frame_done", n_done - s_done, 1);
      check("post-abort ch_write", {29'd0, last_chw}, 32'b100);
      compare_words("post-abort");

      // Jittered 1 MHz stream of random frames.
      jitter  = 1'b1;
      half_lo = 20;
      half_hi = 20;
      snap();
      for (int f = 0; f < 16; f++)
         send_frame(2'($urandom_range(2)), $urandom, 4);
      repeat (40) @(negedge clk);
      check("random frame_start", n_start - s_start, 16);
      check("random frame_done", n_done - s_done, 16);
      check("random frame_err", n_err - s_err, 0);
      check("random sync_lost", n_lost - s_lost, 0);
      compare_words("random");
      check("stray ch_write", n_stray, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
